// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Receives a program image as a byte stream and writes it into instruction
//   memory. The image is a little-endian 32-bit word stream. The loader checks
//   an XOR checksum, then raises `start` to release the core's PC.
//
//   Frame layout: len_lo, len_hi (word count N), 4*N payload bytes, checksum.
//   The checksum is the XOR of the payload bytes only.
//
// Ports
//   clk, reset           : clock and synchronous active-high reset
//   load_req             : one-cycle request to begin a load
//   rx_data/rx_valid     : incoming byte stream
//   rx_ready             : registered; high in LEN0, LEN1, DATA and CHECK
//   imem_we/addr/wdata   : one-cycle word write into instruction memory
//   start                : program valid, core may run
//   busy/done/error      : load status
//   err_code             : 00 none, 01 length overflow, 10 checksum, 11 timeout
//   words_loaded         : words written in the current or last load
//
// Optional feature
//   `define IMEM_BOOT_LOADER_TIMEOUT_EN adds an inter-byte idle counter.
//   The load aborts with err_code 11 after TIMEOUT_CYCLES cycles without
//   an accepted byte.
module imem_boot_loader #(
   parameter int unsigned DEPTH_WORDS    = 256,
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_req,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        start,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code,
   output logic [15:0] words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CHECK, S_DONE, S_ERROR
   } state_t;

   state_t      state_reg, state_next;
   logic [15:0] len_reg, len_next;
   logic [23:0] shift_reg, shift_next;     // first three bytes of the word
   logic [1:0]  byte_idx_reg, byte_idx_next;
   logic [7:0]  csum_reg, csum_next;
   logic [15:0] words_reg, words_next;
   logic        rx_ready_reg, rx_ready_next;
   logic        we_reg, we_next;
   logic [31:0] addr_reg, addr_next;
   logic [31:0] wdata_reg, wdata_next;
   logic        start_reg, start_next;
   logic        busy_reg, busy_next;
   logic        done_reg, done_next;
   logic        error_reg, error_next;
   logic [1:0]  err_code_reg, err_code_next;
   logic        accept;
   logic [15:0] len_full;

`ifdef IMEM_BOOT_LOADER_TIMEOUT_EN
   logic [31:0] idle_cnt_reg, idle_cnt_next;
`endif

   assign accept   = rx_valid && rx_ready_reg;
   assign len_full = {rx_data, len_reg[7:0]};

   always_comb begin
      state_next    = state_reg;
      len_next      = len_reg;
      shift_next    = shift_reg;
      byte_idx_next = byte_idx_reg;
      csum_next     = csum_reg;
      words_next    = words_reg;
      we_next       = 1'b0;
      addr_next     = addr_reg;
      wdata_next    = wdata_reg;
      err_code_next = err_code_reg;
`ifdef IMEM_BOOT_LOADER_TIMEOUT_EN
      idle_cnt_next = idle_cnt_reg;
`endif

      if (load_req && (state_reg == S_IDLE || state_reg == S_DONE ||
                       state_reg == S_ERROR)) begin
         state_next    = S_LEN0;
         len_next      = '0;
         byte_idx_next = '0;
         csum_next     = '0;
         words_next    = '0;
         err_code_next = 2'b00;
`ifdef IMEM_BOOT_LOADER_TIMEOUT_EN
         idle_cnt_next = '0;
`endif
      end else begin
         case (state_reg)
            S_LEN0: if (accept) begin
               len_next   = {8'h00, rx_data};
               state_next = S_LEN1;
            end
            S_LEN1: if (accept) begin
               len_next = len_full;
               if ({16'd0, len_full} > DEPTH_WORDS) begin
                  state_next    = S_ERROR;
                  err_code_next = 2'b01;
               end else if (len_full == 16'd0) begin
                  state_next = S_CHECK;
               end else begin
                  state_next = S_DATA;
               end
            end
            S_DATA: if (accept) begin
               csum_next     = csum_reg ^ rx_data;
               byte_idx_next = byte_idx_reg + 2'd1;
               if (byte_idx_reg == 2'd3) begin
                  // The write happens in the next cycle. Moving to CHECK on
                  // the same edge lets the checksum byte be taken during the
                  // write cycle, so the stream never stalls.
                  we_next    = 1'b1;
                  wdata_next = {rx_data, shift_reg};
                  addr_next  = BASE_ADDR + {14'd0, words_reg, 2'b00};
                  if ({16'd0, words_reg} < DEPTH_WORDS)
                     words_next = words_reg + 16'd1;
                  if (words_reg + 16'd1 == len_reg)
                     state_next = S_CHECK;
               end else begin
                  shift_next = {rx_data, shift_reg[23:8]};
               end
            end
            S_CHECK: if (accept) begin
               if (rx_data == csum_reg) begin
                  state_next = S_DONE;
               end else begin
                  state_next    = S_ERROR;
                  err_code_next = 2'b10;
               end
            end
            default: ;
         endcase

`ifdef IMEM_BOOT_LOADER_TIMEOUT_EN
         if (state_reg == S_LEN0 || state_reg == S_LEN1 ||
             state_reg == S_DATA || state_reg == S_CHECK) begin
            if (accept) begin
               idle_cnt_next = '0;
            end else if (idle_cnt_reg >= TIMEOUT_CYCLES - 1) begin
               state_next    = S_ERROR;
               err_code_next = 2'b11;
            end else begin
               idle_cnt_next = idle_cnt_reg + 32'd1;
            end
         end
`endif
      end

      // Status outputs are registered decodes of the next state.
      busy_next     = (state_next == S_LEN0) || (state_next == S_LEN1) ||
                      (state_next == S_DATA) || (state_next == S_CHECK);
      rx_ready_next = busy_next;
      done_next     = (state_next == S_DONE);
      start_next    = (state_next == S_DONE);
      error_next    = (state_next == S_ERROR);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= S_IDLE;
         len_reg      <= '0;
         shift_reg    <= '0;
         byte_idx_reg <= '0;
         csum_reg     <= '0;
         words_reg    <= '0;
         rx_ready_reg <= 1'b0;
         we_reg       <= 1'b0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         start_reg    <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         error_reg    <= 1'b0;
         err_code_reg <= 2'b00;
`ifdef IMEM_BOOT_LOADER_TIMEOUT_EN
         idle_cnt_reg <= '0;
`endif
      end else begin
         state_reg    <= state_next;
         len_reg      <= len_next;
         shift_reg    <= shift_next;
         byte_idx_reg <= byte_idx_next;
         csum_reg     <= csum_next;
         words_reg    <= words_next;
         rx_ready_reg <= rx_ready_next;
         we_reg       <= we_next;
         addr_reg     <= addr_next;
         wdata_reg    <= wdata_next;
         start_reg    <= start_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
         error_reg    <= error_next;
         err_code_reg <= err_code_next;
`ifdef IMEM_BOOT_LOADER_TIMEOUT_EN
         idle_cnt_reg <= idle_cnt_next;
`endif
      end
   end

   assign rx_ready     = rx_ready_reg;
   assign imem_we      = we_reg;
   assign imem_addr    = addr_reg;
   assign imem_wdata   = wdata_reg;
   assign start        = start_reg;
   assign busy         = busy_reg;
   assign done         = done_reg;
   assign error        = error_reg;
   assign err_code     = err_code_reg;
   assign words_loaded = words_reg;

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream of the RV32I core. Receives a program image as a byte stream over a valid/ready link.
- Assembles bytes into little-endian 32-bit words and writes them into instruction memory through its write port.
- Verifies an XOR checksum, then raises `start` to release the pipeline's PC.
- Holds `start` low during a load, so the core never fetches a partially written image.

Parameters:
- DEPTH_WORDS, 256: instruction-memory capacity in words; the maximum accepted image length.
- BASE_ADDR, 32'h0000_0000: byte address of the first written word.
- TIMEOUT_CYCLES, 1024: inter-byte idle limit. Used only when the optional feature is enabled.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- load_req  input  1  single-cycle request to begin a load.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader can accept a byte.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  32  byte address of the write; word-aligned.
- imem_wdata  output  32  word to write.
- start  output  1  level to pc_register; high means the program is valid and may run.
- busy  output  1  load in progress.
- done  output  1  last load succeeded.
- error  output  1  last load failed.
- err_code  output  2  00 none, 01 length overflow, 10 checksum mismatch, 11 timeout.
- words_loaded  output  16  number of words written in the current or last load.

Behaviour:
- Clocking and reset: one clock, `clk`. `reset` is synchronous and active-high.
- Reset values: all outputs are 0, including `imem_addr`, `imem_wdata` and `words_loaded`. State is IDLE.
- Byte handshake: a byte is accepted on a clock edge where rx_valid && rx_ready.
- rx_ready is registered. It is 1 only in states LEN0, LEN1, DATA and CHECK.
- Frame format: len_lo, len_hi (16-bit word count N, little endian), then 4*N payload bytes (little endian per word), then 1 checksum byte.
- Checksum: XOR of all payload bytes. Length bytes are excluded.
- State IDLE:
  - On load_req, go to LEN0.
  - Set busy=1; clear start, done, error, err_code, words_loaded and the checksum accumulator.
- State LEN0: accept len_lo, then go to LEN1.
- State LEN1: accept len_hi, then:
  - If N > DEPTH_WORDS, go to ERROR with err_code=01.
  - Else if N == 0, go to CHECK.
  - Else go to DATA.
- State DATA:
  - A 2-bit byte index and a shift register assemble each word; byte 0 goes to bits [7:0].
  - Every accepted byte is XORed into the accumulator.
  - On the 4th byte: in the next cycle imem_we=1 for exactly one cycle, imem_wdata = the assembled word, imem_addr = BASE_ADDR + 4*words_loaded (pre-increment value). words_loaded increments in that same cycle.
  - After the Nth word's write cycle, go to CHECK.
  - rx_ready stays high during the write cycle. There is no bubble; writes and byte acceptance overlap.
- State CHECK:
  - Accept one byte.
  - If it equals the accumulator, go to DONE.
  - Otherwise go to ERROR with err_code=10.
- State DONE: busy=0, done=1, start=1. start holds until reset or a new load_req.
- State ERROR: busy=0, error=1, start=0. err_code holds.
- Words already written remain in memory after an error; no rollback.
- load_req handling:
  - Ignored while busy.
  - In DONE or ERROR, load_req restarts the load as from IDLE, and start drops in the same cycle the state is left.
- Simultaneous reset and load_req: reset wins.
- Reset mid-load: return to IDLE with all outputs 0. Partial memory contents are left as is.
- words_loaded saturates at DEPTH_WORDS. It cannot exceed this because of the length check.
- imem_addr wraps modulo 2^32. This is unreachable for legal parameters.

Optional Feature:
- Macro: IMEM_BOOT_LOADER_TIMEOUT_EN.
- Enabled:
  - A counter runs in LEN0, LEN1, DATA and CHECK. It resets on each accepted byte.
  - When it reaches TIMEOUT_CYCLES with no byte accepted, go to ERROR with err_code=11 and rx_ready=0 in the next cycle.
- Disabled: no counter; the loader waits indefinitely. err_code 11 is never produced.

Test Plan:
- Two-word load. Stream 02 00 | 13 00 00 00 | 93 00 50 00 | D0 with rx_valid held high.
  - Required: writes (addr 0x0, data 0x00000013) and (addr 0x4, data 0x00500093), each one-cycle imem_we.
  - Then done=1, start=1, words_loaded=2, err_code=00.
- Same stream with 1-3 cycle rx_valid gaps between bytes: identical writes and result, and no byte lost or duplicated.
- Same stream with checksum D1.
  - Required: both writes occur, then error=1, err_code=10, start=0, rx_ready=0.
- Length overflow with DEPTH_WORDS=256. Stream 01 01.
  - Required: error=1, err_code=01 immediately after len_hi, no imem_we, rx_ready=0.
- Zero length. Stream 00 00 00.
  - Required: done=1, start=1, words_loaded=0, no imem_we.
- Reset asserted after 5 payload bytes.
  - Required: next cycle all outputs are 0 and the state is IDLE.
  - A subsequent full two-word load succeeds.
- (With IMEM_BOOT_LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=16) Stop after len_hi and wait 16 cycles.
  - Required: err_code=11, error=1, start=0.
